// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;
   typedef enum logic {RUN, MEM_WAIT} state_t;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_t;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
   // x0 is hardwired zero, so it never produces a dependency
   function automatic logic hit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
      return wr && dst != 5'd0 && dst == src;
   endfunction
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != CNT_MAX) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: forwarding select for one EX operand; the younger MEM result wins over WB.
module fwd_sel_unit
   import pipe_ctrl_pkg::*;
(
   input  logic       en,
   input  logic [4:0] src,
   input  logic       mem_wr,
   input  logic [4:0] mem_wnum,
   input  logic       wb_wr,
   input  logic [4:0] wb_wnum,
   output logic [1:0] sel
);
   always_comb
      sel = !en                         ? FWD_RF  :
            hit(mem_wr, mem_wnum, src)  ? FWD_MEM :
            hit(wb_wr, wb_wnum, src)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/forward control with memory watchdog and perf counters.
// Define PIPE_CTRL_FWD_EN to enable forwarding with load-use stalls; otherwise every EX/MEM dependency stalls.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  reg_anum_id,
   input  logic [4:0]  reg_bnum_id,
   input  logic [4:0]  ex_reg_anum,
   input  logic [4:0]  ex_reg_bnum,
   input  logic        ex_reg_wr,
   input  logic        ex_mem_load,
   input  logic [4:0]  ex_reg_wnum,
   input  logic        mem_reg_wr,
   input  logic [4:0]  mem_reg_wnum,
   input  logic        wb_reg_wr,
   input  logic [4:0]  wb_reg_wnum,
   input  logic        ex_branch_taken,
   input  logic        mem_busy,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_id,
   output logic        bubble_ex,
   output logic        stall_ex,
   output logic        stall_mem,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);
   state_t      state, state_nx;
   logic [31:0] wd, wd_inc;
   logic        hz, freeze, flush, hold, fwd_en;
`ifdef PIPE_CTRL_FWD_EN
   assign fwd_en = !rst;
   assign hz     = id_valid && ex_mem_load &&
                   (hit(ex_reg_wr, ex_reg_wnum, reg_anum_id) || hit(ex_reg_wr, ex_reg_wnum, reg_bnum_id));
`else
   logic unused_load;
   assign unused_load = ex_mem_load;
   assign fwd_en      = 1'b0;
   // WB is written before ID reads the regfile, so only EX and MEM can conflict
   assign hz          = id_valid &&
                        (hit(ex_reg_wr, ex_reg_wnum, reg_anum_id)   || hit(ex_reg_wr, ex_reg_wnum, reg_bnum_id) ||
                         hit(mem_reg_wr, mem_reg_wnum, reg_anum_id) || hit(mem_reg_wr, mem_reg_wnum, reg_bnum_id));
`endif
   assign freeze    = !rst && mem_busy;
   assign flush     = !rst && !mem_busy && ex_branch_taken;
   assign hold      = !rst && !mem_busy && !ex_branch_taken && hz;
   assign stall_if  = freeze || hold;
   assign stall_id  = freeze || hold;
   assign stall_ex  = freeze;
   assign stall_mem = freeze;
   assign flush_id  = flush;
   assign bubble_ex = flush || hold;
   assign wd_inc    = sat_inc(wd, 1'b1);
   fwd_sel_unit u_fwd_a (
      .en(fwd_en), .src(ex_reg_anum), .mem_wr(mem_reg_wr), .mem_wnum(mem_reg_wnum),
      .wb_wr(wb_reg_wr), .wb_wnum(wb_reg_wnum), .sel(fwd_a_sel)
   );
   fwd_sel_unit u_fwd_b (
      .en(fwd_en), .src(ex_reg_bnum), .mem_wr(mem_reg_wr), .mem_wnum(mem_reg_wnum),
      .wb_wr(wb_reg_wr), .wb_wnum(wb_reg_wnum), .sel(fwd_b_sel)
   );
   always_comb begin
      state_nx = state;
      case (state)
         RUN:      state_nx = mem_busy ? MEM_WAIT : RUN;
         MEM_WAIT: state_nx = mem_busy ? MEM_WAIT : RUN;
         default:  state_nx = RUN;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wd           <= '0;
         mem_timeout  <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state        <= state_nx;
         wd           <= mem_busy ? wd_inc : '0;
         mem_timeout  <= mem_timeout || (mem_busy && wd_inc >= 32'(MEM_TIMEOUT));
         stall_cycles <= sat_inc(stall_cycles, stall_id);
         flush_count  <= sat_inc(flush_count, flush_id);
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;
   localparam int TO = 4;
   logic        clk = 1'b0, rst;
   logic        id_valid, ex_reg_wr, ex_mem_load, mem_reg_wr, wb_reg_wr, ex_branch_taken, mem_busy;
   logic [4:0]  reg_anum_id, reg_bnum_id, ex_reg_anum, ex_reg_bnum, ex_reg_wnum, mem_reg_wnum, wb_reg_wnum;
   logic        stall_if, stall_id, flush_id, bubble_ex, stall_ex, stall_mem, mem_timeout;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [31:0] stall_cycles, flush_count;
   int          n_chk = 0, n_pass = 0;
   logic [31:0] m_sc, m_fc;
   int          m_wd;
   logic        m_to;

   always #5 clk = ~clk;

   pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .reg_anum_id(reg_anum_id), .reg_bnum_id(reg_bnum_id),
      .ex_reg_anum(ex_reg_anum), .ex_reg_bnum(ex_reg_bnum),
      .ex_reg_wr(ex_reg_wr), .ex_mem_load(ex_mem_load), .ex_reg_wnum(ex_reg_wnum),
      .mem_reg_wr(mem_reg_wr), .mem_reg_wnum(mem_reg_wnum),
      .wb_reg_wr(wb_reg_wr), .wb_reg_wnum(wb_reg_wnum),
      .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex),
      .stall_ex(stall_ex), .stall_mem(stall_mem), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic clr_in();
      {id_valid, ex_reg_wr, ex_mem_load, mem_reg_wr, wb_reg_wr, ex_branch_taken, mem_busy} = '0;
      {reg_anum_id, reg_bnum_id, ex_reg_anum, ex_reg_bnum, ex_reg_wnum, mem_reg_wnum, wb_reg_wnum} = '0;
   endtask

   function automatic bit dep(input logic wr, input logic [4:0] dst);
      return wr && dst != 0 && (dst == reg_anum_id || dst == reg_bnum_id);
   endfunction

`ifdef PIPE_CTRL_FWD_EN
   function automatic logic [1:0] pick(input logic [4:0] src);
      if (src == 0) return 2'd0;
      if (mem_reg_wr && mem_reg_wnum == src) return 2'd1;
      if (wb_reg_wr && wb_reg_wnum == src) return 2'd2;
      return 2'd0;
   endfunction
`endif

   // check outputs mid-cycle against the model, then advance the model across the next edge
   task automatic cycle();
      bit fr, br, hz, st;
      logic [1:0] ea, eb;
      @(negedge clk);
      ea = 2'd0;
      eb = 2'd0;
`ifdef PIPE_CTRL_FWD_EN
      hz = id_valid && ex_mem_load && dep(ex_reg_wr, ex_reg_wnum);
      if (!rst) begin
         ea = pick(ex_reg_anum);
         eb = pick(ex_reg_bnum);
      end
`else
      hz = id_valid && (dep(ex_reg_wr, ex_reg_wnum) || dep(mem_reg_wr, mem_reg_wnum));
`endif
      fr = !rst && mem_busy;
      br = !rst && !mem_busy && ex_branch_taken;
      st = !rst && !mem_busy && !ex_branch_taken && hz;
      chk("stall_if", 32'(stall_if), 32'(fr || st));
      chk("stall_id", 32'(stall_id), 32'(fr || st));
      chk("stall_ex", 32'(stall_ex), 32'(fr));
      chk("stall_mem", 32'(stall_mem), 32'(fr));
      chk("flush_id", 32'(flush_id), 32'(br));
      chk("bubble_ex", 32'(bubble_ex), 32'(br || st));
      chk("fwd_a_sel", 32'(fwd_a_sel), 32'(ea));
      chk("fwd_b_sel", 32'(fwd_b_sel), 32'(eb));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
      chk("stall_cycles", stall_cycles, m_sc);
      chk("flush_count", flush_count, m_fc);
      if (rst) begin
         m_sc = 0; m_fc = 0; m_wd = 0; m_to = 1'b0;
      end else begin
         if ((fr || st) && m_sc != 32'hFFFF_FFFF) m_sc++;
         if (br && m_fc != 32'hFFFF_FFFF) m_fc++;
         if (mem_busy) begin
            m_wd++;
            if (m_wd >= TO) m_to = 1'b1;
         end else m_wd = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      m_sc = 'x; m_fc = 'x; m_wd = 0; m_to = 1'bx;
      clr_in();
      rst = 1'b1;
      @(posedge clk);
      #1;
      m_sc = 0; m_fc = 0; m_to = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();
      // load-use on operand A
      id_valid = 1; ex_mem_load = 1; ex_reg_wr = 1; ex_reg_wnum = 5; reg_anum_id = 5;
      cycle();
      clr_in();
      cycle();
      chk("lu_sc", stall_cycles, 32'd1);
      // forwarding priority MEM > WB > none
      ex_reg_anum = 7; mem_reg_wr = 1; mem_reg_wnum = 7; wb_reg_wr = 1; wb_reg_wnum = 7;
      cycle();
      mem_reg_wr = 0;
      cycle();
      ex_reg_anum = 0; mem_reg_wr = 1; mem_reg_wnum = 0; wb_reg_wnum = 0;
      cycle();
      // branch held through a 3-cycle freeze
      clr_in(); rst = 1; cycle(); rst = 0;
      ex_branch_taken = 1; mem_busy = 1;
      repeat (3) cycle();
      mem_busy = 0;
      cycle();
      ex_branch_taken = 0;
      cycle();
      chk("br_fc", flush_count, 32'd1);
      // watchdog
      rst = 1; cycle(); rst = 0;
      mem_busy = 1;
      repeat (6) cycle();
      mem_busy = 0;
      repeat (2) cycle();
      chk("wd_sticky", 32'(mem_timeout), 32'd1);
      rst = 1; cycle(); rst = 0;
      cycle();
      // reset while waiting on memory
      mem_busy = 1; id_valid = 1; ex_reg_wr = 1; ex_reg_wnum = 2; reg_bnum_id = 2;
      repeat (2) cycle();
      rst = 1; cycle(); rst = 0; mem_busy = 0;
      cycle();
      // MEM-stage dependency on operand B
      clr_in();
      id_valid = 1; mem_reg_wr = 1; mem_reg_wnum = 3; reg_bnum_id = 3;
      cycle();
      clr_in();
      for (int i = 0; i < 3000; i++) begin
         rst             = ($urandom_range(0, 63) == 0);
         id_valid        = $urandom_range(0, 3) != 0;
         reg_anum_id     = 5'($urandom_range(0, 3));
         reg_bnum_id     = 5'($urandom_range(0, 3));
         ex_reg_anum     = 5'($urandom_range(0, 3));
         ex_reg_bnum     = 5'($urandom_range(0, 3));
         ex_reg_wnum     = 5'($urandom_range(0, 3));
         mem_reg_wnum    = 5'($urandom_range(0, 3));
         wb_reg_wnum     = 5'($urandom_range(0, 3));
         ex_reg_wr       = 1'($urandom);
         ex_mem_load     = 1'($urandom);
         mem_reg_wr      = 1'($urandom);
         wb_reg_wr       = 1'($urandom);
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         mem_busy        = ($urandom_range(0, 3) == 0) || (mem_busy && $urandom_range(0, 7) != 0);
         cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: mem_busy cycles tolerated before mem_timeout sets.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning); clock and reset first:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- reg_anum_id, reg_bnum_id  in  5 each  ID source registers
- ex_reg_anum, ex_reg_bnum  in  5 each  EX source registers
- ex_reg_wr, ex_mem_load  in  1 each  EX writes reg / EX is load
- ex_reg_wnum  in  5  EX destination
- mem_reg_wr  in  1  MEM writes reg
- mem_reg_wnum  in  5  MEM destination
- wb_reg_wr  in  1  WB writes reg
- wb_reg_wnum  in  5  WB destination
- ex_branch_taken  in  1  EX redirects PC
- mem_busy  in  1  data memory not ready
- stall_if, stall_id  out  1 each  hold PC / hold IF-ID register
- flush_id  out  1  kill IF-ID contents
- bubble_ex  out  1  load NOP into ID-EX
- stall_ex, stall_mem  out  1 each  hold ID-EX / EX-MEM
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 EX-MEM, 10 MEM-WB
- mem_timeout  out  1  sticky watchdog flag
- stall_cycles, flush_count  out  32 each  perf counters

Function
REQ-003 SHALL implement FSM {RUN, MEM_WAIT}: RUN->MEM_WAIT when mem_busy=1; MEM_WAIT holds while mem_busy=1; MEM_WAIT->RUN the cycle after mem_busy=0.
REQ-004 SHALL treat mem_busy=1 (any state) as freeze: stall_if, stall_id, stall_ex, stall_mem all 1; flush_id, bubble_ex 0.
REQ-005 SHALL, when not frozen and ex_branch_taken=1, assert flush_id=1 and bubble_ex=1 in the same cycle; stalls 0; flush_count increments once per such cycle.
REQ-006 SHALL resolve priority as: rst > mem_busy freeze > branch flush > data-hazard stall.
REQ-007 SHALL detect load-use when id_valid & ex_mem_load & ex_reg_wr & ex_reg_wnum!=0 & ex_reg_wnum matches reg_anum_id or reg_bnum_id; response: stall_if=stall_id=bubble_ex=1 for exactly that cycle.
REQ-008 SHALL compute fwd_x_sel per EX operand: 01 if mem_reg_wr & mem_reg_wnum!=0 & match; else 10 if wb_reg_wr & wb_reg_wnum!=0 & match; else 00 (MEM wins over WB).
REQ-009 SHALL never forward or stall on register x0.
REQ-010 SHALL count mem_busy cycles in a watchdog counter, cleared when mem_busy=0; mem_timeout sets when the count reaches MEM_TIMEOUT and stays set until rst.
REQ-011 SHALL increment stall_cycles on every cycle with stall_id=1; both perf counters saturate at 32'hFFFF_FFFF.
REQ-012 All stall/flush/fwd outputs SHALL be combinational from inputs and state (zero latency); counters and flags registered.

Reset
REQ-013 SHALL, on rst=1 at a clk edge, enter RUN and clear watchdog, mem_timeout, stall_cycles, flush_count to 0.
REQ-014 SHALL drive all stall/flush/bubble outputs 0 and fwd sels 00 while rst=1, including reset mid-MEM_WAIT.

Configuration
REQ-015 SHALL honour macro PIPE_CTRL_FWD_EN: defined -> REQ-007/REQ-008 behaviour.
REQ-016 Without PIPE_CTRL_FWD_EN: fwd sels tied 00; stall_if=stall_id=bubble_ex=1 whenever id_valid and an ID source (non-x0) matches a writing EX or MEM destination; WB matches do not stall (regfile write-before-read).

Structure
REQ-017 SHALL place state enum (RUN, MEM_WAIT) and fwd select enum (FWD_RF=00, FWD_MEM=01, FWD_WB=10) in shared package pipe_ctrl_pkg.
REQ-018 SHALL use one sub-module fwd_sel_unit computing one operand's select, instantiated twice.

Verification
REQ-019 Load-use: ex_mem_load=1, ex_reg_wnum=5, reg_anum_id=5, id_valid=1 -> stall_if/stall_id/bubble_ex=1 one cycle, stall_cycles +1.
REQ-020 Forward priority: ex_reg_anum=7, mem_reg_wnum=7, wb_reg_wnum=7, both wr=1 -> fwd_a_sel=01; drop mem_reg_wr -> 10; x0 -> 00.
REQ-021 Branch during freeze: ex_branch_taken=1, mem_busy=1 for 3 cycles -> full freeze 3 cycles, then flush_id=1 one cycle, flush_count=1.
REQ-022 Watchdog: MEM_TIMEOUT=4, mem_busy held 6 cycles -> mem_timeout=1 after 4th busy cycle, stays 1 after mem_busy=0 until rst.
REQ-023 Reset mid-wait: rst in MEM_WAIT -> next cycle state RUN, counters 0, all stalls 0.
REQ-024 FWD_EN off: mem_reg_wr=1, mem_reg_wnum=3, reg_bnum_id=3 -> stall_id=1, bubble_ex=1, fwd sels 00.
